single_mips_instruction_memory: RTL and testbench

- Responder end of the program-counter fetch interface. It takes the instruction address from the program counter and returns the 32-bit instruction word in the same cycle.
- Contains a byte-serial program loader FSM with a valid/ready handshake. The loader fills the word array big-endian before or between runs.
- Flags misaligned and out-of-range fetches.

---
 rtl/single_mips_instruction_memory.sv | 171 +++++++++++++++++
 tb/tb_single_mips_instruction_memory.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/single_mips_instruction_memory.sv
`default_nettype none
// ============================================================================
// Module   : single_mips_instruction_memory
// Brief    : Zero-latency instruction fetch memory with a byte-serial,
//            big-endian program loader. Optional macro IMEM_LOAD_CHECKSUM_EN
//            adds a load_checksum output.
// Revision : 1.0 - initial release
// ============================================================================
module single_mips_instruction_memory #(
    parameter int          ADDR_WIDTH  = 32,
    parameter int          DEPTH_WORDS = 256,
    parameter logic [31:0] NOP_WORD    = 32'h0000_0000
) (
    input  logic                           CLK,
    input  logic                           RST,
    input  logic [ADDR_WIDTH-1:0]          ins_addr,
    output logic [31:0]                    instruction,
    output logic                           addr_fault,
    input  logic                           load_start,
    input  logic [7:0]                     load_byte,
    input  logic                           load_valid,
    input  logic                           load_last,
    output logic                           load_ready,
    output logic                           load_busy,
    output logic                           load_done,
    output logic                           load_overflow,
    output logic [$clog2(DEPTH_WORDS):0]   load_word_count
`ifdef IMEM_LOAD_CHECKSUM_EN
    ,
    output logic [31:0]                    load_checksum
`endif
);

    localparam int          AW      = $clog2(DEPTH_WORDS);
    localparam logic [AW:0] C_DEPTH = (AW+1)'(DEPTH_WORDS);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOAD = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]  state_q, state_d;
    logic [AW:0] ptr_q, ptr_d;
    logic [1:0]  bcnt_q, bcnt_d;
    logic [31:0] asm_q, asm_d;
    logic [AW:0] wcnt_q, wcnt_d;
    logic        ovf_q, ovf_d;
`ifdef IMEM_LOAD_CHECKSUM_EN
    logic [31:0] sum_q, sum_d;
`endif

    logic        w_accept;
    logic        w_we;
    logic [31:0] w_word;
    logic        w_oob;
    logic [31:0] mem_q [DEPTH_WORDS];

    // Any address bit above the array span means the fetch is out of range.
    generate
        if (ADDR_WIDTH > AW + 2) begin : g_range
            assign w_oob = |ins_addr[ADDR_WIDTH-1:AW+2];
        end else begin : g_norange
            assign w_oob = 1'b0;
        end
    endgenerate

    assign addr_fault      = (|ins_addr[1:0]) | w_oob;
    assign instruction     = (addr_fault || load_busy) ? NOP_WORD : mem_q[ins_addr[AW+1:2]];
    assign load_busy       = (state_q == ST_LOAD);
    assign load_ready      = (state_q == ST_LOAD);
    assign load_done       = (state_q == ST_DONE);
    assign load_overflow   = ovf_q;
    assign load_word_count = wcnt_q;
    assign w_accept        = load_valid & load_ready;
`ifdef IMEM_LOAD_CHECKSUM_EN
    assign load_checksum   = sum_q;
`endif

    always_comb begin
        // asm_q is cleared after every write, so unfilled bytes pad with zero.
        w_word = asm_q;
        case (bcnt_q)
            2'd0:    w_word[31:24] = load_byte;
            2'd1:    w_word[23:16] = load_byte;
            2'd2:    w_word[15:8]  = load_byte;
            default: w_word[7:0]   = load_byte;
        endcase

        w_we    = 1'b0;
        state_d = state_q;
        ptr_d   = ptr_q;
        bcnt_d  = bcnt_q;
        asm_d   = asm_q;
        wcnt_d  = wcnt_q;
        ovf_d   = ovf_q;
`ifdef IMEM_LOAD_CHECKSUM_EN
        sum_d   = sum_q;
`endif
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (load_start) begin
                    state_d = ST_LOAD;
                    ptr_d   = '0;
                    bcnt_d  = '0;
                    asm_d   = '0;
                    wcnt_d  = '0;
                    ovf_d   = 1'b0;
`ifdef IMEM_LOAD_CHECKSUM_EN
                    sum_d   = '0;
`endif
                end
            end
            ST_LOAD: begin
                if (w_accept) begin
                    if (ptr_q == C_DEPTH) begin
                        ovf_d   = 1'b1;
                        state_d = ST_DONE;
                    end else if (bcnt_q == 2'd3 || load_last) begin
                        w_we   = 1'b1;
                        ptr_d  = ptr_q + 1'b1;
                        wcnt_d = wcnt_q + 1'b1;
                        bcnt_d = '0;
                        asm_d  = '0;
`ifdef IMEM_LOAD_CHECKSUM_EN
                        sum_d  = sum_q + w_word;
`endif
                        if (load_last) begin
                            state_d = ST_DONE;
                        end
                    end else begin
                        asm_d  = w_word;
                        bcnt_d = bcnt_q + 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            bcnt_q  <= '0;
            asm_q   <= '0;
            wcnt_q  <= '0;
            ovf_q   <= 1'b0;
`ifdef IMEM_LOAD_CHECKSUM_EN
            sum_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            bcnt_q  <= bcnt_d;
            asm_q   <= asm_d;
            wcnt_q  <= wcnt_d;
            ovf_q   <= ovf_d;
`ifdef IMEM_LOAD_CHECKSUM_EN
            sum_q   <= sum_d;
`endif
        end
    end

    // Program storage survives reset; only a committed load word is written.
    always_ff @(posedge CLK) begin
        if (w_we && !RST) begin
            mem_q[ptr_q[AW-1:0]] <= w_word;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_single_mips_instruction_memory.sv
`default_nettype none
// ============================================================================
// Module   : tb_single_mips_instruction_memory
// Brief    : Self-checking bench for single_mips_instruction_memory.
// Revision : 1.0 - initial release
// ============================================================================
module tb_single_mips_instruction_memory;

    localparam int DEPTH = 256;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic [31:0] ins_addr = '0;
    logic [31:0] instruction;
    logic        addr_fault;
    logic        load_start = 1'b0;
    logic [7:0]  load_byte = '0;
    logic        load_valid = 1'b0;
    logic        load_last = 1'b0;
    logic        load_ready, load_busy, load_done, load_overflow;
    logic [8:0]  load_word_count;
`ifdef IMEM_LOAD_CHECKSUM_EN
    logic [31:0] load_checksum;
`endif

    single_mips_instruction_memory #(
        .ADDR_WIDTH (32),
        .DEPTH_WORDS(DEPTH),
        .NOP_WORD   (32'h0000_0000)
    ) u_dut (
        .CLK            (CLK),
        .RST            (RST),
        .ins_addr       (ins_addr),
        .instruction    (instruction),
        .addr_fault     (addr_fault),
        .load_start     (load_start),
        .load_byte      (load_byte),
        .load_valid     (load_valid),
        .load_last      (load_last),
        .load_ready     (load_ready),
        .load_busy      (load_busy),
        .load_done      (load_done),
        .load_overflow  (load_overflow),
        .load_word_count(load_word_count)
`ifdef IMEM_LOAD_CHECKSUM_EN
        ,
        .load_checksum  (load_checksum)
`endif
    );

    always #5 CLK = ~CLK;

    typedef struct {
        string       tag;
        logic [32:0] exp;
    } exp_t;

    exp_t        sb[$];
    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] model_mem [DEPTH];
    logic [31:0] model_sum;
    logic [7:0]  img[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s got %h expected %h", tag, obs, exp);
        end
    endtask

    // Expected words built straight from the byte image, zero-padded.
    task automatic model_words(input logic [7:0] bytes[$], input int nwords);
        model_sum = '0;
        for (int w = 0; w < nwords; w++) begin
            logic [31:0] word;
            word = '0;
            for (int k = 0; k < 4; k++) begin
                if (4*w + k < bytes.size()) word[31-8*k -: 8] = bytes[4*w+k];
            end
            model_mem[w] = word;
            model_sum    = model_sum + word;
        end
    endtask

    task automatic pulse_start();
        @(negedge CLK);
        load_start = 1'b1;
        @(negedge CLK);
        load_start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic last);
        @(negedge CLK);
        load_byte  = b;
        load_valid = 1'b1;
        load_last  = last;
    endtask

    task automatic idle();
        @(negedge CLK);
        load_valid = 1'b0;
        load_last  = 1'b0;
    endtask

    task automatic send_image(input logic [7:0] bytes[$], input bit use_last);
        for (int i = 0; i < bytes.size(); i++) begin
            send_byte(bytes[i], use_last && (i == bytes.size() - 1));
        end
        idle();
    endtask

    task automatic fetch(input string tag, input logic [31:0] addr,
                         input logic [31:0] exp_ins, input logic exp_fault);
        exp_t e;
        @(negedge CLK);
        ins_addr = addr;
        sb.push_back('{tag: tag, exp: {exp_fault, exp_ins}});
        #1;
        e = sb.pop_front();
        check(e.tag, {31'd0, addr_fault, instruction}, {31'd0, e.exp});
    endtask

    initial begin
        // Reset state
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        RST = 1'b0;
        #1;
        check("rst_done",  load_done, 0);
        check("rst_busy",  load_busy, 0);
        check("rst_ready", load_ready, 0);
        check("rst_ovf",   load_overflow, 0);
        check("rst_wcnt",  load_word_count, 0);
        check("rst_fault", addr_fault, 0);

        // Full-word load
        img = '{8'h8C, 8'h01, 8'h00, 8'h04, 8'h20, 8'h02, 8'h00, 8'h05};
        model_words(img, 2);
        pulse_start();
        #1;
        check("load_busy", load_busy, 1);
        fetch("busy_nop", 32'h0, 32'h0, 1'b0);
        send_image(img, 1'b1);
        #1;
        check("full_wcnt", load_word_count, 2);
        check("full_done", load_done, 1);
        check("full_ready", load_ready, 0);
        fetch("full_w0", 32'h0, model_mem[0], 1'b0);
        fetch("full_w1", 32'h4, model_mem[1], 1'b0);
        check("full_w0_const", model_mem[0], 32'h8C01_0004);
`ifdef IMEM_LOAD_CHECKSUM_EN
        check("full_csum", load_checksum, 32'hAC03_0009);
`endif

        // Partial last word
        img = '{8'hAA, 8'hBB, 8'hCC};
        model_words(img, 1);
        pulse_start();
        send_image(img, 1'b1);
        #1;
        check("part_wcnt", load_word_count, 1);
        fetch("part_w0", 32'h0, 32'hAABB_CC00, 1'b0);
        fetch("part_w1_kept", 32'h4, 32'h2002_0005, 1'b0);
`ifdef IMEM_LOAD_CHECKSUM_EN
        check("part_csum", load_checksum, model_sum);
`endif

        // Faults
        fetch("flt_mis2", 32'h2, 32'h0, 1'b1);
        fetch("flt_mis1", 32'h5, 32'h0, 1'b1);
        fetch("flt_oob", 32'h400, 32'h0, 1'b1);
        fetch("flt_high", 32'h8000_0000, 32'h0, 1'b1);

        // Overflow: 4*DEPTH+1 bytes, load_last never asserted
        img.delete();
        for (int i = 0; i < 4*DEPTH + 1; i++) img.push_back(8'(i*7 + 3));
        model_words(img, DEPTH);
        pulse_start();
        for (int i = 0; i < 4*DEPTH; i++) send_byte(img[i], 1'b0);
        @(negedge CLK);
        load_valid = 1'b0;
        #1;
        check("ovf_full_busy", load_busy, 1);
        check("ovf_full_flag", load_overflow, 0);
        send_byte(img[4*DEPTH], 1'b0);
        idle();
        #1;
        check("ovf_flag", load_overflow, 1);
        check("ovf_done", load_done, 1);
        check("ovf_wcnt", load_word_count, DEPTH);
        fetch("ovf_w255", 32'h3FC, model_mem[DEPTH-1], 1'b0);
        fetch("ovf_w0", 32'h0, model_mem[0], 1'b0);

        // Abort via reset after 6 accepted bytes
        img = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
        pulse_start();
        #1;
        check("ovf_cleared", load_overflow, 0);
        for (int i = 0; i < 6; i++) send_byte(img[i], 1'b0);
        @(negedge CLK);
        load_valid = 1'b0;
        RST        = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        #1;
        check("abort_ready", load_ready, 0);
        check("abort_busy",  load_busy, 0);
        check("abort_done",  load_done, 0);
        check("abort_wcnt",  load_word_count, 0);
        fetch("abort_w0", 32'h0, 32'h1122_3344, 1'b0);
        fetch("abort_w1", 32'h4, model_mem[1], 1'b0);

        // load_start mid-LOAD is ignored
        img = '{8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h01, 8'h23, 8'h45, 8'h67};
        model_words(img, 2);
        pulse_start();
        for (int i = 0; i < 5; i++) send_byte(img[i], 1'b0);
        idle();
        pulse_start();
        #1;
        check("intl_busy", load_busy, 1);
        for (int i = 5; i < 8; i++) send_byte(img[i], i == 7);
        idle();
        #1;
        check("intl_wcnt", load_word_count, 2);
        fetch("intl_w0", 32'h0, model_mem[0], 1'b0);
        fetch("intl_w1", 32'h4, model_mem[1], 1'b0);
`ifdef IMEM_LOAD_CHECKSUM_EN
        check("intl_csum", load_checksum, model_sum);
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
